// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - single-port instruction memory arbiter between fetch and loader
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   f_req/f_addr/f_flush       fetch request, word address (PC), discard in-flight fetch
//   f_ready/f_valid/f_instr    fetch accept pulse, result pulse, instruction word
//   f_err                      qualifies f_valid: address outside the memory
//   l_req/l_we/l_addr/l_wdata  loader request, write select, word address, write data
//   l_gnt/l_done/l_rdata       loader accept pulse, completion pulse, read data
//   mem_en/mem_we/mem_addr     memory strobe, write enable, word address
//   mem_wdata/mem_rdata        memory write data, read data (MEM_LAT cycles after mem_en)

module imem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_flush,
    output logic              f_ready,
    output logic              f_valid,
    output logic [31:0]       f_instr,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_done,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [2:0]  LAT       = 3'(MEM_LAT);
    localparam logic [3:0]  SMAX      = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_WAIT,
        LOAD_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        flushed_q, flushed_d;
    logic        err_pend_q, err_pend_d;
    logic        load_wr_q, load_wr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        fetch_win;
    logic        fetch_oor;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        flushed_d  = flushed_q;
        err_pend_d = 1'b0;
        load_wr_d  = load_wr_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;

        f_ready    = 1'b0;
        f_valid    = 1'b0;
        f_instr    = instr_q;
        f_err      = 1'b0;
        l_gnt      = 1'b0;
        l_done     = 1'b0;
        l_rdata    = rdata_q;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        // Fetch has priority unless the loader has been passed over too often.
        fetch_win  = f_req && !(l_req && (starve_q == SMAX));
        fetch_oor  = (f_addr >> ADDR_W) != 32'd0;

        // An out-of-range fetch is answered locally one cycle after f_ready,
        // while the FSM stays in IDLE.
        if (err_pend_q) begin
            f_valid = 1'b1;
            f_err   = 1'b1;
            f_instr = NOP_INSTR;
        end

        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    f_ready = 1'b1;
                    if (fetch_oor) begin
                        err_pend_d = 1'b1;
                        instr_d    = NOP_INSTR;
                    end else begin
                        mem_en    = 1'b1;
                        mem_addr  = f_addr[ADDR_W-1:0];
                        cnt_d     = LAT;
                        flushed_d = 1'b0;
                        state_d   = FETCH_WAIT;
                    end
                end else if (l_req) begin
                    l_gnt     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = l_we;
                    mem_addr  = l_addr;
                    mem_wdata = l_wdata;
                    load_wr_d = l_we;
                    cnt_d     = LAT;
                    state_d   = LOAD_WAIT;
                end
            end
            FETCH_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Completion is the cycle in which the counter steps to zero.
                if (cnt_q == 3'd1) begin
                    state_d   = IDLE;
                    flushed_d = 1'b0;
                    if (!flushed_q && !f_flush) begin
                        f_valid = 1'b1;
                        f_instr = mem_rdata;
                        instr_d = mem_rdata;
                    end
                end else if (f_flush) begin
                    flushed_d = 1'b1;
                end
            end
            LOAD_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    l_done  = 1'b1;
                    if (!load_wr_q) begin
                        l_rdata = mem_rdata;
                        rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!l_req || l_gnt) begin
            starve_d = 4'd0;
        end else if (f_ready && (starve_q != SMAX)) begin
            starve_d = starve_q + 4'd1;
        end

        // Nothing is granted or reported while reset is held.
        if (reset) begin
            f_ready   = 1'b0;
            f_valid   = 1'b0;
            f_instr   = '0;
            f_err     = 1'b0;
            l_gnt     = 1'b0;
            l_done    = 1'b0;
            l_rdata   = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            starve_q   <= 4'd0;
            flushed_q  <= 1'b0;
            err_pend_q <= 1'b0;
            load_wr_q  <= 1'b0;
            instr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            flushed_q  <= flushed_d;
            err_pend_q <= err_pend_d;
            load_wr_q  <= load_wr_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
